axi_stream_conv_pipe: RTL

AXI-Stream shell for the 2D convolution engine. It adds full valid/ready backpressure using credit-based flow control and a fixed-latency engine interface. An output FIFO absorbs in-flight results, and TLAST is carried alongside the data. It sits between the DMA S2MM/MM2S streams and a fixed-latency, non-stallable convolution datapath. The engine datapath is external to this block.

---
 rtl/axi_conv_pkg.sv | 28 ++
 rtl/axi_stream_conv_pipe_fifo.sv | 71 +++++++
 rtl/axi_stream_conv_pipe.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/axi_conv_pkg.sv
// ---------------------------------------------------------------------------
// axi_conv_pkg
// Shared definitions for the convolution stream blocks:
//   NB_PIXEL_DEF / NB_LANES_DEF : default pixel width and lanes per beat
//   DATA_WIDTH_DEF              : default beat width (NB_LANES_DEF*NB_PIXEL_DEF)
//   beat_t                      : {tlast, data} beat at the default geometry
//   lane_slice()                : extracts pixel lane k from a default-width beat
// ---------------------------------------------------------------------------
package axi_conv_pkg;

    localparam int NB_PIXEL_DEF   = 8;
    localparam int NB_LANES_DEF   = 4;
    localparam int DATA_WIDTH_DEF = NB_LANES_DEF * NB_PIXEL_DEF;

    typedef struct packed {
        logic                      tlast;
        logic [DATA_WIDTH_DEF-1:0] data;
    } beat_t;

    // Lane k occupies bits [k*NB_PIXEL +: NB_PIXEL]
    function automatic logic [NB_PIXEL_DEF-1:0] lane_slice(
        input logic [DATA_WIDTH_DEF-1:0] data,
        input int unsigned               k
    );
        return data[k*NB_PIXEL_DEF +: NB_PIXEL_DEF];
    endfunction

endpackage

// File: rtl/axi_stream_conv_pipe_fifo.sv
// ---------------------------------------------------------------------------
// conv_out_fifo
// Synchronous first-word-fall-through FIFO; the head entry is always visible
// on dout while not empty.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset (pointers/count)
//   push, din      : write request and data (accepted when not full, or when
//                    a pop frees a slot in the same cycle)
//   pop            : consume head entry (ignored when empty)
//   dout           : head entry
//   empty, full    : status
//   count          : occupancy, $clog2(DEPTH+1) bits
// ---------------------------------------------------------------------------
module conv_out_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    // Pointers wrap modulo DEPTH, which need not be a power of two
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // At full a simultaneous pop frees the slot being written
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; only entries behind the pointers are ever read
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/axi_stream_conv_pipe.sv
// ---------------------------------------------------------------------------
// axi_stream_conv_pipe
// AXI-Stream shell around a fixed-latency, non-stallable convolution engine.
// Credits (free result slots) gate s_axis_tready so every beat sent to the
// engine is guaranteed a place in the output FIFO when its result returns.
// Ports:
//   i_clk, i_reset                   : clock, synchronous active-high reset
//   s_axis_t{valid,data,last,ready}  : input stream
//   m_axis_t{valid,data,last,ready}  : output stream (results + delayed tlast)
//   o_eng_valid, o_eng_data          : registered beat issued to the engine
//   i_eng_data                       : engine result, ENG_LATENCY after issue
//   o_frame_err                      : sticky frame-length error
// Optional build macro CONV_FRAME_CHECK_EN adds the frame-length checker;
// without it o_frame_err is constant 0.
// ---------------------------------------------------------------------------
module axi_stream_conv_pipe
    import axi_conv_pkg::*;
#(
    parameter int NB_PIXEL    = NB_PIXEL_DEF,
    parameter int NB_LANES    = NB_LANES_DEF,
    parameter int DATA_WIDTH  = NB_LANES * NB_PIXEL,
    parameter int ENG_LATENCY = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int FRAME_BEATS = 10000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  o_eng_valid,
    output logic [DATA_WIDTH-1:0] o_eng_data,
    input  logic [DATA_WIDTH-1:0] i_eng_data,
    output logic                  o_frame_err
);
    localparam int CW = $clog2(FIFO_DEPTH+1);

    if (ENG_LATENCY < 1) begin : g_bad_latency
        $error("ENG_LATENCY must be >= 1");
    end
    if (FIFO_DEPTH < ENG_LATENCY + 2) begin : g_bad_depth
        $error("FIFO_DEPTH must be >= ENG_LATENCY+2");
    end
    if (FRAME_BEATS < 1) begin : g_bad_frame
        $error("FRAME_BEATS must be >= 1");
    end

    logic                  accept, pop;
    logic [CW-1:0]         credits_q, credits_d;
    logic                  eng_valid_q, eng_last_q;
    logic [DATA_WIDTH-1:0] eng_data_q;
    logic [ENG_LATENCY:1]  vld_pipe_q, last_pipe_q;
    logic                  fifo_empty, fifo_full;
    logic [CW-1:0]         fifo_count;
    logic [DATA_WIDTH:0]   fifo_dout;
    logic                  unused_fifo_status;

    assign accept = s_axis_tvalid & s_axis_tready;
    assign pop    = m_axis_tvalid & m_axis_tready;

    // Credits = FIFO slots not yet claimed by a buffered or in-flight beat
    always_comb begin
        credits_d = credits_q;
        case ({accept, pop})
            2'b10:   credits_d = credits_q - CW'(1);
            2'b01:   credits_d = credits_q + CW'(1);
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) credits_q <= CW'(FIFO_DEPTH);
        else         credits_q <= credits_d;
    end

    assign s_axis_tready = (credits_q != '0);

    // Engine issue register; tlast rides along in eng_last_q
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            eng_valid_q <= 1'b0;
            eng_data_q  <= '0;
            eng_last_q  <= 1'b0;
        end else begin
            eng_valid_q <= accept;
            if (accept) begin
                eng_data_q <= s_axis_tdata;
                eng_last_q <= s_axis_tlast;
            end
        end
    end

    assign o_eng_valid = eng_valid_q;
    assign o_eng_data  = eng_data_q;

    // Delay line matching the engine latency; stage ENG_LATENCY lines up
    // with the cycle i_eng_data carries the result for that beat
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
        end else begin
            vld_pipe_q[1]  <= eng_valid_q;
            last_pipe_q[1] <= eng_last_q;
            for (int k = 2; k <= ENG_LATENCY; k++) begin
                vld_pipe_q[k]  <= vld_pipe_q[k-1];
                last_pipe_q[k] <= last_pipe_q[k-1];
            end
        end
    end

    conv_out_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .push    (vld_pipe_q[ENG_LATENCY]),
        .pop     (m_axis_tready),
        .din     ({last_pipe_q[ENG_LATENCY], i_eng_data}),
        .dout    (fifo_dout),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    // Credits already prevent overflow, so the status outputs go unused here
    assign unused_fifo_status = &{1'b0, fifo_full, fifo_count};

    assign m_axis_tvalid = ~fifo_empty;
    assign m_axis_tdata  = fifo_dout[DATA_WIDTH-1:0];
    // Qualified so tlast reads 0 while nothing is presented (FIFO storage
    // itself is not reset)
    assign m_axis_tlast  = ~fifo_empty & fifo_dout[DATA_WIDTH];

`ifdef CONV_FRAME_CHECK_EN
    localparam int FCW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;

    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic           frame_err_q, frame_err_d;
    logic           at_end;

    assign at_end = (frame_cnt_q == FCW'(FRAME_BEATS-1));

    // Error when tlast and the final-beat position disagree; either one
    // starts a new frame count
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        frame_err_d = frame_err_q;
        if (accept) begin
            frame_cnt_d = (s_axis_tlast | at_end) ? '0 : frame_cnt_q + FCW'(1);
            if (s_axis_tlast != at_end) frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            frame_cnt_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign o_frame_err = frame_err_q;
`else
    assign o_frame_err = 1'b0;
`endif

endmodule
